// File: rtl/snow64_instr_cache_pkg.sv
// Shared types and geometry constants for the snow64 instruction cache.
// The port structs use the default widths; the state encoding is kept legacy-compatible.
package PkgSnow64InstrCache;

  localparam int WIDTH__INSTR       = 32;
  localparam int WIDTH__WORD_OFFSET = 3;  // 8 instructions per line
  localparam int WIDTH__LINE_OFFSET = 5;  // 32 bytes per line

  localparam int DEFAULT_NUM_LINES   = 64;
  localparam int DEFAULT_WIDTH__ADDR = 64;
  localparam int DEFAULT_WIDTH__LINE = 256;

  function automatic int index_width(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_width(input int width_addr, input int num_lines);
    return width_addr - WIDTH__LINE_OFFSET - $clog2(num_lines);
  endfunction

  localparam int WIDTH__INDEX = index_width(DEFAULT_NUM_LINES);
  localparam int WIDTH__TAG   = tag_width(DEFAULT_WIDTH__ADDR, DEFAULT_NUM_LINES);

  typedef logic [0:0] state_t;
  localparam state_t StIdle = 1'b0;
  localparam state_t StFill = 1'b1;

  typedef struct packed {
    logic                           req;
    logic [DEFAULT_WIDTH__ADDR-1:0] addr;
  } PortIn_Snow64InstrCache_FromIfId;

  typedef struct packed {
    logic                    valid;
    logic [WIDTH__INSTR-1:0] instr;
  } PortOut_Snow64InstrCache_ToIfId;

  typedef struct packed {
    logic                           valid;
    logic [DEFAULT_WIDTH__LINE-1:0] data;
  } PortIn_Snow64InstrCache_FromMem;

  typedef struct packed {
    logic                           req;
    logic [DEFAULT_WIDTH__ADDR-1:0] addr;
  } PortOut_Snow64InstrCache_ToMem;

endpackage

// File: rtl/snow64_instr_cache_line_ram.sv
// Tag/valid/data storage for the instruction cache: asynchronous read, one write
// port, and a bulk clear of every valid bit on reset.
module snow64_instr_cache_line_ram #(
  parameter int NUM_LINES   = 64,
  parameter int INDEX_WIDTH = $clog2(NUM_LINES),
  parameter int TAG_WIDTH   = 53,
  parameter int LINE_WIDTH  = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic                   rd_valid,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic [LINE_WIDTH-1:0]  rd_data,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [LINE_WIDTH-1:0]  wr_data
);

  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_WIDTH-1:0]  tag_mem  [NUM_LINES];
  logic [LINE_WIDTH-1:0] data_mem [NUM_LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately left without reset; a cleared
  // valid bit already masks whatever they hold, and this keeps them RAM-mappable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/snow64_instr_cache.sv
// Direct-mapped read-only instruction cache between IF/ID and the memory arbiter.
// Hits answer one cycle after the request; misses fill a whole line, then re-look-up.
module snow64_instr_cache
  import PkgSnow64InstrCache::*;
#(
  parameter int NUM_LINES   = 64,
  parameter int WIDTH__ADDR = 64,
  parameter int WIDTH__LINE = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_from_if_id_req,
  input  logic [WIDTH__ADDR-1:0] in_from_if_id_addr,
  output logic                   out_to_if_id_valid,
  output logic [31:0]            out_to_if_id_instr,
  output logic                   out_to_mem_req,
  output logic [WIDTH__ADDR-1:0] out_to_mem_addr,
  input  logic                   in_from_mem_valid,
  input  logic [WIDTH__LINE-1:0] in_from_mem_data
);

  localparam int IDX_W   = index_width(NUM_LINES);
  localparam int TAG_W   = tag_width(WIDTH__ADDR, NUM_LINES);
  localparam int TAG_LSB = WIDTH__LINE_OFFSET + IDX_W;

  state_t                         state_q;
  PortOut_Snow64InstrCache_ToIfId to_if_id_q;
  logic                           mem_req_q;
  logic [WIDTH__ADDR-1:0]         mem_addr_q;

  logic [IDX_W-1:0]              req_index;
  logic [TAG_W-1:0]              req_tag;
  logic [WIDTH__WORD_OFFSET-1:0] req_word;
  logic                          rd_valid;
  logic [TAG_W-1:0]              rd_tag;
  logic [WIDTH__LINE-1:0]        rd_data;
  logic                          hit;
  logic [WIDTH__INSTR-1:0]       hit_word;
  logic                          fill_en;
  logic [1:0]                    unused_byte_offset;

  assign req_index          = in_from_if_id_addr[TAG_LSB-1:WIDTH__LINE_OFFSET];
  assign req_tag            = in_from_if_id_addr[WIDTH__ADDR-1:TAG_LSB];
  assign req_word           = in_from_if_id_addr[WIDTH__LINE_OFFSET-1:2];
  assign unused_byte_offset = in_from_if_id_addr[1:0];

  assign hit      = rd_valid && (rd_tag == req_tag);
  assign hit_word = rd_data[{req_word, 5'b0} +: WIDTH__INSTR];

  // The fill writes the index/tag captured at miss time, not the live request.
  assign fill_en = (state_q == StFill) && in_from_mem_valid;

  snow64_instr_cache_line_ram #(
    .NUM_LINES  (NUM_LINES),
    .INDEX_WIDTH(IDX_W),
    .TAG_WIDTH  (TAG_W),
    .LINE_WIDTH (WIDTH__LINE)
  ) u_line_ram (
    .clk     (clk),
    .rst     (rst),
    .rd_index(req_index),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (fill_en),
    .wr_index(mem_addr_q[TAG_LSB-1:WIDTH__LINE_OFFSET]),
    .wr_tag  (mem_addr_q[WIDTH__ADDR-1:TAG_LSB]),
    .wr_data (in_from_mem_data)
  );

  // NOTE: every register here uses non-blocking assignment so all updates on an
  // edge see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      to_if_id_q <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          to_if_id_q.valid <= 1'b0;
          if (in_from_if_id_req) begin
            if (hit) begin
              to_if_id_q.valid <= 1'b1;
              to_if_id_q.instr <= hit_word;
            end else begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= {in_from_if_id_addr[WIDTH__ADDR-1:WIDTH__LINE_OFFSET],
                             {WIDTH__LINE_OFFSET{1'b0}}};
              state_q    <= StFill;
            end
          end
        end
        default: begin
          to_if_id_q.valid <= 1'b0;
          if (in_from_mem_valid) begin
            mem_req_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
      endcase
    end
  end

  assign out_to_if_id_valid = to_if_id_q.valid;
  assign out_to_if_id_instr = to_if_id_q.instr;
  assign out_to_mem_req     = mem_req_q;
  assign out_to_mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_snow64_instr_cache.sv
// Scoreboard bench for snow64_instr_cache: a line-level cache model predicts each
// response and fill; an independent negedge monitor compares what the DUT presents.
module tb_snow64_instr_cache;

  localparam int NUM_LINES = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         if_req = 1'b0;
  logic [63:0]  if_addr = '0;
  logic         out_valid;
  logic [31:0]  out_instr;
  logic         mem_req;
  logic [63:0]  mem_addr;
  logic         mem_valid = 1'b0;
  logic [255:0] mem_data = '0;

  always #5 clk = ~clk;

  snow64_instr_cache #(
    .NUM_LINES  (NUM_LINES),
    .WIDTH__ADDR(64),
    .WIDTH__LINE(256)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_from_if_id_req (if_req),
    .in_from_if_id_addr(if_addr),
    .out_to_if_id_valid(out_valid),
    .out_to_if_id_instr(out_instr),
    .out_to_mem_req    (mem_req),
    .out_to_mem_addr   (mem_addr),
    .in_from_mem_valid (mem_valid),
    .in_from_mem_data  (mem_data)
  );

  typedef struct packed { int unsigned due; logic [31:0] instr; } resp_t;
  typedef struct packed { int unsigned due; logic [63:0] addr; }  fill_t;

  resp_t       exp_resp[$];
  fill_t       exp_fill[$];
  int unsigned exp_drop[$];

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model: which line address each index holds, plus one pending fill.
  bit          m_valid [NUM_LINES];
  logic [63:0] m_line  [NUM_LINES];
  bit          m_filling;
  logic [63:0] m_fill_addr;
  int          m_lat;
  int          force_lat = -1;
  bit          spurious_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] line, input int k);
    if (line == 64'h1000) return 32'hA000_0000 + 32'(k);
    return line[31:0] ^ line[63:32] ^ (32'h1111_1111 * 32'(k)) ^ 32'h5EED_0000;
  endfunction

  function automatic logic [255:0] line_data(input logic [63:0] line);
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = mem_word(line, k);
    return d;
  endfunction

  function automatic logic [63:0] line_of(input logic [63:0] a);
    return {a[63:5], 5'b0};
  endfunction

  function automatic int idx_of(input logic [63:0] a);
    return int'((a >> 5) % NUM_LINES);
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = 64'h4000 + 64'($urandom_range(0, 23)) * 64'd32 + 64'($urandom_range(0, 31));
    if ($urandom_range(0, 3) == 0) a[63] = 1'b1;
    return a;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_LINES; i++) begin
      m_valid[i] = 1'b0;
      m_line[i]  = '0;
    end
    m_filling = 1'b0;
    exp_resp.delete();
    exp_fill.delete();
    exp_drop.delete();
  endtask

  // One clock cycle: drive inputs, advance the model to the coming edge, step.
  task automatic cycle(input logic req, input logic [63:0] addr);
    logic [63:0] line;
    int          idx;
    int          fidx;
    resp_t       r;
    fill_t       f;
    line    = line_of(addr);
    idx     = idx_of(addr);
    if_req  = req;
    if_addr = addr;
    mem_valid = 1'b0;
    for (int k = 0; k < 8; k++) mem_data[k*32 +: 32] = $urandom;
    if (m_filling) begin
      if (m_lat == 0) begin
        mem_valid = 1'b1;
        mem_data  = line_data(m_fill_addr);
        fidx      = idx_of(m_fill_addr);
        m_valid[fidx] = 1'b1;
        m_line[fidx]  = m_fill_addr;
        m_filling     = 1'b0;
        exp_drop.push_back(edge_cnt + 1);
      end else begin
        m_lat--;
      end
    end else begin
      if (spurious_en && $urandom_range(0, 7) == 0) mem_valid = 1'b1;
      if (req) begin
        if (m_valid[idx] && m_line[idx] == line) begin
          r.due   = edge_cnt + 1;
          r.instr = mem_word(line, int'(addr[4:2]));
          exp_resp.push_back(r);
        end else begin
          m_filling   = 1'b1;
          m_fill_addr = line;
          m_lat       = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 5));
          f.due  = edge_cnt + 1;
          f.addr = line;
          exp_fill.push_back(f);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fill(input logic req, input logic [63:0] addr);
    for (int i = 0; i < 64 && m_filling; i++) cycle(req, addr);
  endtask

  task automatic reset_now();
    rst = 1'b1;
    #1;
    check("rst_if_id_valid", 128'(out_valid), 128'd0);
    check("rst_if_id_instr", 128'(out_instr), 128'd0);
    check("rst_mem_req",     128'(mem_req),   128'd0);
    check("rst_mem_addr",    128'(mem_addr),  128'd0);
    model_clear();
    if_req    = 1'b0;
    mem_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compares DUT outputs once per cycle, away from the active edge.
  logic        prev_req  = 1'b0;
  logic [63:0] prev_addr = '0;
  resp_t       mon_r;
  fill_t       mon_f;

  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (exp_resp.size() > 0 && exp_resp[0].due == edge_cnt) begin
        mon_r = exp_resp.pop_front();
        check("hit_resp", {out_valid, out_instr}, {1'b1, mon_r.instr});
      end else begin
        check("no_resp", 128'(out_valid), 128'd0);
      end
      if (prev_req) begin
        if (exp_drop.size() > 0 && exp_drop[0] == edge_cnt) begin
          void'(exp_drop.pop_front());
          check("fill_drop", 128'(mem_req), 128'd0);
        end else begin
          check("fill_hold", {mem_req, mem_addr}, {1'b1, prev_addr});
        end
      end else begin
        if (exp_fill.size() > 0 && exp_fill[0].due == edge_cnt) begin
          mon_f = exp_fill.pop_front();
          check("fill_req", {mem_req, mem_addr}, {1'b1, mon_f.addr});
        end else begin
          check("no_fill", 128'(mem_req), 128'd0);
        end
      end
      prev_req  = mem_req;
      prev_addr = mem_addr;
    end
  end

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;

    // Cold miss with a fixed memory latency, then the re-lookup hit.
    force_lat = 2;
    cycle(1'b1, 64'h1000);
    wait_fill(1'b1, 64'h1000);
    cycle(1'b1, 64'h1000);

    // Remaining words of the resident line on consecutive cycles.
    for (int k = 1; k < 8; k++) cycle(1'b1, 64'h1000 + 64'(4 * k));

    // Conflict eviction at the same index.
    cycle(1'b1, 64'h1000 + 64'(32 * NUM_LINES));
    wait_fill(1'b1, 64'h1000 + 64'(32 * NUM_LINES));
    cycle(1'b1, 64'h1000);
    wait_fill(1'b1, 64'h1000);
    cycle(1'b1, 64'h1000);

    // Address change while a fill is outstanding.
    force_lat = 4;
    cycle(1'b1, 64'h2000);
    wait_fill(1'b1, 64'h3000);
    cycle(1'b1, 64'h3000);
    wait_fill(1'b1, 64'h3000);
    cycle(1'b1, 64'h3004);

    // Idle.
    for (int i = 0; i < 5; i++) cycle(1'b0, rand_addr());

    // Randomized traffic with stray memory pulses while idle.
    force_lat   = -1;
    spurious_en = 1'b1;
    for (int i = 0; i < 400; i++) cycle($urandom_range(0, 4) != 0, rand_addr());
    wait_fill(1'b0, 64'h0);
    spurious_en = 1'b0;

    // Reset in the middle of a fill, then a late memory pulse.
    force_lat = 20;
    cycle(1'b1, 64'h9000);
    cycle(1'b1, 64'h9000);
    cycle(1'b1, 64'h9000);
    check("pre_rst_mem_req", 128'(mem_req), 128'd1);
    reset_now();
    if_req    = 1'b0;
    mem_valid = 1'b1;
    mem_data  = line_data(64'h2000);
    @(posedge clk);
    @(negedge clk);
    #1;
    mem_valid = 1'b0;
    force_lat = 1;
    cycle(1'b1, 64'h2000);
    wait_fill(1'b1, 64'h2000);
    cycle(1'b1, 64'h2008);

    repeat (3) cycle(1'b0, 64'h0);
    check("drain", 128'(exp_resp.size() + exp_fill.size() + exp_drop.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
